// File: rtl/fifo_pkg.sv
// Shared types and default sizes for the pixel FIFO reader and controller.
package fifo_pkg;

    localparam int unsigned PIX_WIDTH_DEF = 16;
    localparam int unsigned CNT_WIDTH_DEF = 8;
    localparam int unsigned TIMEOUT_DEF   = 15;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DONE
    } reader_state_t;

endpackage

// File: rtl/fifo_reader_counter.sv
// Loadable up/down counter that saturates at either end instead of wrapping.
module counter #(
    parameter int unsigned WIDTH          = 8,
    parameter bit          inverseCounter = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = data;
        end else if (en) begin
            if (inverseCounter) begin
                if (count_q != '0) count_d = count_q - ONE;
            end else begin
                if (count_q != '1) count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains a programmed number of pixels from the FIFO read port and forwards them on valid/ready.
// Define FIFO_READER_CHECKSUM_EN to add an XOR checksum of delivered pixels.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int unsigned PIX_WIDTH = PIX_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] length,
    output logic                 req_out,
    input  logic                 ack_in,
    input  logic [PIX_WIDTH-1:0] pix_in,
    output logic                 pix_valid,
    output logic [PIX_WIDTH-1:0] pix_data,
    input  logic                 pix_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] remaining
`ifdef FIFO_READER_CHECKSUM_EN
    ,
    output logic [PIX_WIDTH-1:0] checksum
`endif
);

    localparam int unsigned      TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    reader_state_t        state_q, state_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [PIX_WIDTH-1:0] pix_data_q, pix_data_d;
    logic                 pix_valid_q, pix_valid_d;
    logic                 err_q, err_d;
    logic                 cnt_load, cnt_dec;

    // Only a start accepted in IDLE may reload the count; a start while busy is dropped.
    counter #(
        .WIDTH          (CNT_WIDTH),
        .inverseCounter (1'b1)
    ) u_remaining (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .data  (length),
        .en    (cnt_dec),
        .count (remaining)
    );

    always_comb begin
        state_d     = state_q;
        tmo_d       = '0;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        err_d       = err_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        req_out     = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    err_d    = 1'b0;
                    state_d  = (length != '0) ? REQ : DONE;
                end
            end
            REQ: begin
                req_out = 1'b1;
                if (ack_in) begin
                    pix_data_d  = pix_in;
                    pix_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    tmo_d = (tmo_q == TMO_LIMIT) ? tmo_q : tmo_q + TMO_ONE;
                    if (tmo_d == TMO_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            HOLD: begin
                if (pix_ready) begin
                    cnt_dec     = 1'b1;
                    pix_valid_d = 1'b0;
                    state_d     = (remaining == CNT_ONE) ? DONE : REQ;
                end
            end
            DONE: begin
                done        = 1'b1;
                pix_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            err_q       <= err_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign timeout_err = err_q;

`ifdef FIFO_READER_CHECKSUM_EN
    logic [PIX_WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && start)           csum_d = '0;
        else if (state_q == HOLD && pix_ready)  csum_d = csum_q ^ pix_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: burst table plus hand sequences for reset and stall corners.
module tb_fifo_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  length;
    logic        req_out;
    logic        ack_in;
    logic [15:0] pix_in;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [7:0]  remaining;
`ifdef FIFO_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    always #5 clk = ~clk;

    fifo_reader #(
        .PIX_WIDTH (16),
        .CNT_WIDTH (8),
        .TIMEOUT   (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .length      (length),
        .req_out     (req_out),
        .ack_in      (ack_in),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .remaining   (remaining)
`ifdef FIFO_READER_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    typedef struct {
        int          len;
        int          delay;      // REQ cycles before the FIFO acks
        bit          never;      // FIFO never acks
        int          stall;      // pix_ready low cycles on the first beat
        int          base;       // first entry of pix_tab supplied
        bit          spur;       // extra start pulse while busy
        int          exp_beats;
        bit          exp_err;
        int          exp_rem;
        int          exp_req;
        logic [15:0] exp_csum;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] pix_tab [8];
    vec_t        vecs    [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int  beats, acks, req_cyc, req_run, stall_cnt, dones;
        bit  fin;
        beats = 0; acks = 0; req_cyc = 0; req_run = 0; stall_cnt = 0; dones = 0; fin = 0;
        @(negedge clk);
        start = 1'b1; length = 8'(v.len); ack_in = 1'b0; pix_ready = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (v.spur && cyc == 2) begin
                start = 1'b1; length = 8'd5;
            end else begin
                start = 1'b0;
            end
            ack_in    = req_out && !v.never && (req_run == v.delay);
            pix_in    = pix_tab[(v.base + acks) % 8];
            pix_ready = pix_valid && (beats > 0 || stall_cnt >= v.stall);
            if (pix_valid && !pix_ready) begin
                stall_cnt++;
                check("stall_data_held", pix_data, pix_tab[v.base % 8]);
                check("stall_no_req", req_out, 1'b0);
                check("stall_remaining", remaining, v.len);
            end
            if (pix_valid && pix_ready) begin
                check("beat_data", pix_data, pix_tab[(v.base + beats) % 8]);
                check("beat_remaining", remaining, v.len - beats);
                beats++;
            end
            if (ack_in) acks++;
            if (req_out) begin
                req_cyc++; req_run++;
            end else begin
                req_run = 0;
            end
            if (done) begin
                dones++; fin = 1;
                if (v.len == 0) check("len0_done_latency", cyc, 0);
            end
            @(negedge clk);
        end
        start = 1'b0; ack_in = 1'b0; pix_ready = 1'b0;
        check("burst_finished", fin, 1'b1);
        check("done_pulse_width", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
        check("valid_low_after_done", pix_valid, 1'b0);
        check("beat_count", beats, v.exp_beats);
        check("done_count", dones, 1);
        check("req_cycles", req_cyc, v.exp_req);
        check("timeout_err", timeout_err, v.exp_err);
        check("final_remaining", remaining, v.exp_rem);
`ifdef FIFO_READER_CHECKSUM_EN
        check("checksum", checksum, v.exp_csum);
`endif
    endtask

    initial begin
        pix_tab[0] = 16'h50ff; pix_tab[1] = 16'h308e; pix_tab[2] = 16'h08f1;
        pix_tab[3] = 16'h2575; pix_tab[4] = 16'hafe1; pix_tab[5] = 16'h1234;
        pix_tab[6] = 16'h5678; pix_tab[7] = 16'h9abc;
        //          len dly nev stl base spur beats err rem req csum
        vecs[0] = '{3,  1,  0,  0,  0,   0,   3,    0,  0,  6,  16'h6880};
        vecs[1] = '{2,  1,  0,  4,  0,   0,   2,    0,  0,  4,  16'h6071};
        vecs[2] = '{1,  0,  1,  0,  0,   0,   0,    1,  1,  15, 16'h0000};
        vecs[3] = '{0,  0,  0,  0,  0,   0,   0,    0,  0,  0,  16'h0000};
        vecs[4] = '{2,  0,  0,  0,  0,   0,   2,    0,  0,  2,  16'h6071};
        vecs[5] = '{1,  14, 0,  0,  0,   0,   1,    0,  0,  15, 16'h50ff};
        vecs[6] = '{2,  1,  0,  0,  3,   1,   2,    0,  0,  4,  16'h8a94};

        reset = 1'b0; start = 1'b0; length = '0; ack_in = 1'b0; pix_in = '0; pix_ready = 1'b0;
        #12;
        check("rst_req_out", req_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pix_valid", pix_valid, 1'b0);
        check("rst_pix_data", pix_data, 16'h0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_remaining", remaining, 8'h0);
`ifdef FIFO_READER_CHECKSUM_EN
        check("rst_checksum", checksum, 16'h0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_burst(vecs[i]);

        // Asynchronous reset in the middle of a REQ wait, then a stray ack.
        @(negedge clk);
        start = 1'b1; length = 8'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_req", req_out, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_req_out", req_out, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_pix_valid", pix_valid, 1'b0);
        check("async_remaining", remaining, 8'h0);
        @(negedge clk);
        reset = 1'b1; ack_in = 1'b1; pix_in = 16'hdead;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_ack_busy", busy, 1'b0);
            check("stray_ack_valid", pix_valid, 1'b0);
            check("stray_ack_req", req_out, 1'b0);
            check("stray_ack_data", pix_data, 16'h0);
        end
        ack_in = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
